// File: rtl/store_queue_pkg.sv
// store_queue_pkg: shared sizes and entry record for the store queue (STORE_QUEUE_BYTE_MASK_EN adds the load byte mask)
package store_queue_pkg;
  localparam int SQ_NUM = 8;
  localparam int SQ_WIDTH = $clog2(SQ_NUM);
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
`ifdef STORE_QUEUE_BYTE_MASK_EN
  localparam logic [3:0] LD_MASK = 4'hF;
`endif
  typedef struct packed {
    logic valid;
    logic addr_ok;
    logic committed;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [3:0] mask;
  } sq_entry_t;
endpackage

// File: rtl/store_queue_if.sv
// store_queue_if: dispatch, AGU, ROB, load-lookup and D-cache drain signals of the store queue
interface store_queue_if;
  import store_queue_pkg::*;
  logic alloc_valid;
  logic alloc_ready;
  logic [SQ_WIDTH-1:0] alloc_idx;
  logic fill_valid;
  logic [SQ_WIDTH-1:0] fill_idx;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_data;
  logic [3:0] fill_mask;
  logic commit_valid;
  logic flush;
  logic ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [SQ_WIDTH-1:0] ld_age_idx;
  logic fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic fwd_stall;
  logic mem_valid;
  logic mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [3:0] mem_mask;
  logic empty;
  logic full;
  modport master (
    output alloc_valid, fill_valid, fill_idx, fill_addr, fill_data, fill_mask,
           commit_valid, flush, ld_valid, ld_addr, ld_age_idx, mem_ready,
    input  alloc_ready, alloc_idx, fwd_hit, fwd_data, fwd_stall,
           mem_valid, mem_addr, mem_data, mem_mask, empty, full
  );
  modport slave (
    input  alloc_valid, fill_valid, fill_idx, fill_addr, fill_data, fill_mask,
           commit_valid, flush, ld_valid, ld_addr, ld_age_idx, mem_ready,
    output alloc_ready, alloc_idx, fwd_hit, fwd_data, fwd_stall,
           mem_valid, mem_addr, mem_data, mem_mask, empty, full
  );
endinterface

// File: rtl/store_queue_load_forward_unit.sv
// load_forward_unit: picks the youngest matching entry just below the load's push_head snapshot
module load_forward_unit
  import store_queue_pkg::*;
(
  input  logic [SQ_NUM-1:0]   match,
  input  logic [SQ_WIDTH-1:0] push_head,
  output logic                hit,
  output logic [SQ_WIDTH-1:0] idx
);
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = SQ_NUM - 1; k > 0; k--) begin
      if (match[push_head - SQ_WIDTH'(k)]) begin
        hit = 1'b1;
        idx = push_head - SQ_WIDTH'(k);
      end
    end
  end
endmodule

// File: rtl/store_queue.sv
// store_queue: in-flight store buffer with commit/drain/flush and load forwarding (STORE_QUEUE_BYTE_MASK_EN enables byte-mask forwarding)
module store_queue
  import store_queue_pkg::*;
(
  input logic clk,
  input logic reset,
  store_queue_if.slave sq
);
  sq_entry_t q [SQ_NUM];
  logic [SQ_WIDTH:0] push_head, pop_tail, cmt_ptr, cmt_nxt;
  logic [SQ_WIDTH-1:0] ph, pt, ct, pick_idx;
  logic [SQ_NUM-1:0] word, match, stall_v;
  logic alloc_fire, fill_ok, commit_fire, drain, pick_hit, unused_ok;
  assign ph = push_head[SQ_WIDTH-1:0];
  assign pt = pop_tail[SQ_WIDTH-1:0];
  assign ct = cmt_ptr[SQ_WIDTH-1:0];
  assign sq.full = ph == pt && push_head[SQ_WIDTH] != pop_tail[SQ_WIDTH];
  assign sq.empty = push_head == pop_tail;
  assign sq.alloc_ready = !sq.full;
  assign sq.alloc_idx = ph;
  assign alloc_fire = sq.alloc_valid && sq.alloc_ready && !sq.flush;
  // a committed entry with a known address may be draining, so it is frozen
  assign fill_ok = sq.fill_valid && q[sq.fill_idx].valid &&
                   !(q[sq.fill_idx].committed && q[sq.fill_idx].addr_ok);
  assign commit_fire = sq.commit_valid && q[ct].valid && !q[ct].committed;
  assign cmt_nxt = cmt_ptr + (SQ_WIDTH+1)'(commit_fire);
  assign sq.mem_valid = q[pt].valid && q[pt].committed && q[pt].addr_ok;
  assign drain = sq.mem_valid && sq.mem_ready;
  assign sq.mem_addr = q[pt].addr;
  assign sq.mem_data = q[pt].data;
  assign sq.mem_mask = q[pt].mask;
  assign unused_ok = ^sq.ld_addr[1:0];
  for (genvar g = 0; g < SQ_NUM; g++) begin : g_word
    assign word[g] = q[g].addr[ADDR_W-1:2] == sq.ld_addr[ADDR_W-1:2];
  end
  // older means inside the circular range [pop_tail, ld_age_idx)
  always_comb begin
    match = '0;
    stall_v = '0;
    for (int i = 0; i < SQ_NUM; i++) begin
      if (sq.ld_valid && q[i].valid && (SQ_WIDTH'(i) - pt) < (sq.ld_age_idx - pt)) begin
`ifdef STORE_QUEUE_BYTE_MASK_EN
        match[i] = q[i].addr_ok && word[i] && (q[i].mask & LD_MASK) == LD_MASK;
        stall_v[i] = !q[i].addr_ok || (word[i] && |(q[i].mask & LD_MASK) &&
                     (q[i].mask & LD_MASK) != LD_MASK);
`else
        match[i] = q[i].addr_ok && word[i];
        stall_v[i] = !q[i].addr_ok;
`endif
      end
    end
  end
  load_forward_unit u_lfu (
    .match(match),
    .push_head(sq.ld_age_idx),
    .hit(pick_hit),
    .idx(pick_idx)
  );
  assign sq.fwd_stall = |stall_v;
  assign sq.fwd_hit = pick_hit && !sq.fwd_stall;
  assign sq.fwd_data = q[pick_idx].data;
  always_ff @(posedge clk) begin
    if (reset) begin
      push_head <= '0;
      pop_tail <= '0;
      cmt_ptr <= '0;
      for (int i = 0; i < SQ_NUM; i++) q[i] <= '0;
    end else begin
      if (alloc_fire) begin
        q[ph].valid <= 1'b1;
        q[ph].addr_ok <= 1'b0;
        q[ph].committed <= 1'b0;
      end
      push_head <= push_head + (SQ_WIDTH+1)'(alloc_fire);
      if (fill_ok) begin
        q[sq.fill_idx].addr <= sq.fill_addr;
        q[sq.fill_idx].data <= sq.fill_data;
        q[sq.fill_idx].mask <= sq.fill_mask;
        q[sq.fill_idx].addr_ok <= 1'b1;
      end
      if (commit_fire) q[ct].committed <= 1'b1;
      cmt_ptr <= cmt_nxt;
      if (drain) q[pt].valid <= 1'b0;
      pop_tail <= pop_tail + (SQ_WIDTH+1)'(drain);
      // a store retiring in the flush cycle is older than the flush and survives
      if (sq.flush) begin
        for (int i = 0; i < SQ_NUM; i++)
          if (!q[i].committed && !(commit_fire && SQ_WIDTH'(i) == ct)) q[i] <= '0;
        push_head <= cmt_nxt;
      end
    end
  end
endmodule

// File: doc/store_queue.md
Name: store_queue

Overview:
- Circular buffer of in-flight stores for the superscalar core. It sits between dispatch/execute and data memory.
- Allocates entries in program order and captures address/data from the AGU.
- Marks entries committed on ROB retire, drains committed stores to the D-cache with a valid/ready handshake, and squashes uncommitted entries on flush.
- Produces the per-entry match vector and push_head consumed by the load-forward picker, and returns the forwarded data.

Parameters:
- SQ_NUM, 8 (from common), number of entries; power of two, ≥4.
- SQ_WIDTH, $clog2(SQ_NUM) (from common), entry index width.
- ADDR_W, 32, byte address width.
- DATA_W, 32, store data width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- alloc_valid  in  1  dispatch requests one entry
- alloc_ready  out  1  queue not full
- alloc_idx  out  SQ_WIDTH  index granted (equals push_head)
- fill_valid  in  1  AGU writes address/data
- fill_idx  in  SQ_WIDTH  entry being filled
- fill_addr  in  ADDR_W  store byte address
- fill_data  in  DATA_W  store data
- fill_mask  in  4  byte enables
- commit_valid  in  1  ROB retires the oldest uncommitted store
- flush  in  1  squash all uncommitted entries
- ld_valid  in  1  load lookup request
- ld_addr  in  ADDR_W  load address
- ld_age_idx  in  SQ_WIDTH  push_head sampled when the load was dispatched
- fwd_hit  out  1  youngest older matching store found
- fwd_data  out  DATA_W  data of that store
- fwd_stall  out  1  an older store has an unknown address
- mem_valid  out  1  drain request
- mem_ready  in  1  D-cache accepts
- mem_addr  out  ADDR_W  drain address
- mem_data  out  DATA_W  drain data
- mem_mask  out  4  drain byte enables
- empty  out  1  no entries
- full  out  1  SQ_NUM entries occupied

Behaviour:

State and reset:
- Per-entry state: valid, addr_ok, committed, addr, data, mask.
- Pointers: push_head and pop_tail, each SQ_WIDTH+1 bits; the extra MSB is the wrap bit.
- On reset, all entry bits and both pointers are 0. Outputs at reset: alloc_ready=1, empty=1, full=0, mem_valid=0, fwd_hit=0, fwd_stall=0.

Allocation:
- When alloc_valid && alloc_ready, the entry at push_head becomes valid, with addr_ok=0 and committed=0. push_head increments at the next edge.
- alloc_idx is combinational from push_head.

Full/empty:
- full when the index bits are equal and the wrap bits differ.
- empty when the pointers are equal.

Fill:
- Writes addr/data/mask and sets addr_ok on the same edge.
- A fill to an invalid entry is ignored.

Commit:
- Sets committed on the oldest valid entry that is not yet committed, found via a commit pointer (SQ_WIDTH+1 bits).

Drain:
- mem_valid = entry[pop_tail].valid && committed && addr_ok, registered-free (driven combinationally from the registered entry).
- On mem_valid && mem_ready: clear valid and increment pop_tail.
- mem_addr/mem_data/mem_mask must hold stable while mem_valid && !mem_ready.

Flush:
- Every entry with committed=0 is cleared in one edge.
- push_head is set equal to the commit pointer.
- Committed entries keep draining.
- If flush and alloc occur together, flush wins and the alloc is dropped.

Simultaneous events:
- Alloc, fill, commit and drain in the same cycle are all honoured.
- full/empty are computed from registered pointers only, so alloc into a full queue is rejected even if a drain occurs in the same cycle.

Load lookup (single-cycle combinational, ld_valid gated):
- match[i] = valid && addr_ok && addr[ADDR_W-1:2]==ld_addr[ADDR_W-1:2] && entry i older than the load.
- Age test: i lies in the circular range [pop_tail, ld_age_idx).
- match[] and ld_age_idx (as push_head) feed the picker. fwd_hit/fwd_data come from the chosen index.
- fwd_stall = 1 if any older valid entry has addr_ok=0. When fwd_stall=1, fwd_hit is forced to 0.

Optional Feature:
- STORE_QUEUE_BYTE_MASK_EN defined:
  - match additionally requires the entry mask to cover every byte of the load.
  - Partial overlap (masks intersect but are not covered) asserts fwd_stall instead of fwd_hit.
- Not defined:
  - Word-address compare only; fill_mask is still stored and drained, but is ignored for forwarding.

Decomposition:
- The common package holds SQ_NUM, SQ_WIDTH and a typedef sq_entry_t {valid, addr_ok, committed, addr, data, mask}.
- One sub-module: load_forward_unit, instantiated unchanged for the youngest-match pick.
- Pointer wrap logic stays inline.

Test Plan:
- Reset, then alloc 8 stores → alloc_idx 0..7, full=1 after the 8th; a 9th alloc_valid sees alloc_ready=0 and push_head stays at 0 (wrap bit=1).
- Fill idx 2 with addr 0x100/data 0xAA and idx 5 with 0x100/0xBB; load with ld_age_idx=6 at 0x100 → fwd_hit=1, fwd_data=0xBB; same load with ld_age_idx=4 → 0xAA.
- Alloc idx 0,1; fill only idx 1; load at idx 1's address with ld_age_idx=2 → fwd_stall=1, fwd_hit=0.
- Commit 2 of 4 filled entries, hold mem_ready=0 for 3 cycles → mem_valid=1 with addr/data stable; then ready=1 → two drains, pop_tail=2.
- Flush with 2 committed and 3 uncommitted entries → uncommitted entries cleared, push_head=commit ptr, drains continue, empty=1 after the last drain.
- With STORE_QUEUE_BYTE_MASK_EN: store mask 4'b0011 at 0x200, load 0x200 → fwd_stall=1; store mask 4'b1111 → fwd_hit=1.
